// File: rtl/mem_bus_responder_pkg.sv
// Shared constants and types for the memory-bus responder: IO window select,
// IO register offsets and the read-source tag used by the result mux.
package mem_bus_responder_pkg;

  localparam logic [1:0] IO_SEL  = 2'b11;
  localparam logic [2:0] IO_UART = 3'h0;
  localparam logic [2:0] IO_HALT = 3'h4;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef enum logic {
    SRC_IO  = 1'b0,
    SRC_RAM = 1'b1
  } rd_src_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO of depth 2^AW with occupancy count.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module byte_fifo #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  import mem_bus_responder_pkg::*;

  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = rdy & pop & ~empty;
  assign do_push = rdy & push & (~full | do_pop);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push == True) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop  == True) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage arrays are left unreset; only pointers/count need a known value, and this keeps them mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Responder end of the byte-wide memory bus: byte RAM plus an IO window with
// UART TX/RX FIFOs and a sticky halt register; raises cannot_read near TX full.
module mem_bus_responder #(
  parameter int         RAM_AW  = 17,
  parameter int         FIFO_AW = 3,
  parameter logic [1:0] IO_SEL  = mem_bus_responder_pkg::IO_SEL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_write,
  input  logic        is_write,
  output logic [7:0]  mem_result,
  output logic        cannot_read,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        halt,
  output logic        tx_overflow
);
  import mem_bus_responder_pkg::*;

  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam int TX_DEPTH  = 1 << FIFO_AW;

  // Decode
  logic              is_io;
  logic [2:0]        io_off;
  logic [RAM_AW-1:0] ram_addr;
  logic              unused_addr_bits;

  assign is_io    = (mem_a[17:16] == IO_SEL);
  assign io_off   = mem_a[2:0];
  assign ram_addr = mem_a[RAM_AW-1:0];
  assign unused_addr_bits = ^mem_a;

  // RAM with synchronous read
  logic [7:0] ram_q [RAM_DEPTH];
  logic [7:0] ram_rdata_q;
  logic       ram_we, ram_re;

  assign ram_we = rdy & is_write & ~is_io;
  assign ram_re = rdy & ~is_write & ~is_io;

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_addr] <= mem_write;
    if (ram_re) ram_rdata_q <= ram_q[ram_addr];
  end

  // FIFOs
  logic               tx_push, tx_empty, tx_full;
  logic [7:0]         tx_dout;
  logic [FIFO_AW:0]   tx_count, tx_count_next;
  logic               tx_do_push, tx_do_pop;
  logic               rx_pop, rx_empty, rx_full;
  logic [7:0]         rx_dout;
  logic [FIFO_AW:0]   rx_count;
  logic               unused_rx;

  assign tx_push = is_write & is_io & (io_off == IO_UART);
  assign rx_pop  = ~is_write & is_io & (io_off == IO_UART);
  assign unused_rx = ^{rx_full, rx_count};

  byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .push  (tx_push),
    .din   (mem_write),
    .pop   (uart_tx_ready),
    .dout  (tx_dout),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count)
  );

  byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .push  (uart_rx_valid),
    .din   (uart_rx_data),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

  assign uart_tx_data  = tx_dout;
  assign uart_tx_valid = ~tx_empty;

  // Mirror of the TX FIFO's accept rules, needed to register cannot_read one step ahead.
  assign tx_do_pop     = rdy & uart_tx_ready & ~tx_empty;
  assign tx_do_push    = rdy & tx_push & (~tx_full | tx_do_pop);
  assign tx_count_next = tx_count + (FIFO_AW+1)'(tx_do_push) - (FIFO_AW+1)'(tx_do_pop);

  // Control and read-result state
  rd_src_e    rd_src_q, rd_src_d;
  logic [7:0] io_rdata_q, io_rdata_d;
  logic       halt_q, halt_d;
  logic       tx_overflow_q, tx_overflow_d;
  logic       cannot_read_q, cannot_read_d;

  always_comb begin
    rd_src_d      = rd_src_q;
    io_rdata_d    = io_rdata_q;
    halt_d        = halt_q;
    tx_overflow_d = tx_overflow_q;
    cannot_read_d = cannot_read_q;
    if (rdy) begin
      cannot_read_d = (tx_count_next >= (FIFO_AW+1)'(TX_DEPTH - 1));
      if (tx_push && tx_full && !tx_do_pop) tx_overflow_d = True;
      if (is_write) begin
        if (is_io && io_off == IO_HALT) halt_d = True;
      end else if (is_io) begin
        rd_src_d = SRC_IO;
        unique case (io_off)
          IO_UART: io_rdata_d = rx_empty ? 8'h00 : rx_dout;
          IO_HALT: io_rdata_d = {7'b0, halt_q};
          default: io_rdata_d = 8'h00;
        endcase
      end else begin
        rd_src_d = SRC_RAM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_src_q      <= SRC_IO;
      io_rdata_q    <= 8'h00;
      halt_q        <= False;
      tx_overflow_q <= False;
      cannot_read_q <= False;
    end else begin
      rd_src_q      <= rd_src_d;
      io_rdata_q    <= io_rdata_d;
      halt_q        <= halt_d;
      tx_overflow_q <= tx_overflow_d;
      cannot_read_q <= cannot_read_d;
    end
  end

  // Reset selects the IO source, whose register clears, so mem_result reads 0 from reset.
  assign mem_result  = (rd_src_q == SRC_RAM) ? ram_rdata_q : io_rdata_q;
  assign halt        = halt_q;
  assign tx_overflow = tx_overflow_q;
  assign cannot_read = cannot_read_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed-vector bench for mem_bus_responder with hand-computed expectations.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] mem_a;
  logic [7:0]  mem_write;
  logic        is_write;
  logic [7:0]  mem_result;
  logic        cannot_read;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        halt;
  logic        tx_overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_responder dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .mem_a         (mem_a),
    .mem_write     (mem_write),
    .is_write      (is_write),
    .mem_result    (mem_result),
    .cannot_read   (cannot_read),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .halt          (halt),
    .tx_overflow   (tx_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_write = d; is_write = 1'b1;
    cyc();
    is_write = 1'b0; mem_a = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    mem_a = a; is_write = 1'b0;
    cyc();
    mem_a = 32'h0;
  endtask

  logic [7:0] word_bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  initial begin
    rst = 1'b0; rdy = 1'b1; mem_a = 32'h0; mem_write = 8'h00; is_write = 1'b0;
    uart_tx_ready = 1'b0; uart_rx_data = 8'h00; uart_rx_valid = 1'b0;
    repeat (3) cyc();
    check("rst_mem_result", mem_result, 8'h00);
    check("rst_cannot_read", cannot_read, 1'b0);
    check("rst_halt", halt, 1'b0);
    check("rst_tx_overflow", tx_overflow, 1'b0);
    check("rst_tx_valid", uart_tx_valid, 1'b0);
    rst = 1'b1;
    cyc();

    // RAM write then read
    bus_write(32'h0000_0010, 8'hA5);
    bus_read(32'h0000_0010);
    check("ram_rd_10", mem_result, 8'hA5);

    // Four byte reads back-to-back
    for (int i = 0; i < 4; i++) bus_write(32'h100 + i, word_bytes[i]);
    for (int i = 0; i < 4; i++) begin
      mem_a = 32'h100 + i;
      cyc();
      check($sformatf("word_b%0d", i), mem_result, word_bytes[i]);
    end
    mem_a = 32'h0;

    // Read-after-write, consecutive cycles
    bus_write(32'h200, 8'h77);
    bus_read(32'h200);
    check("raw_200", mem_result, 8'h77);

    // High address bits ignored
    bus_write(32'h0100_0050, 8'h3C);
    bus_read(32'h0000_0050);
    check("alias_50", mem_result, 8'h3C);

    // Halt register and unmapped IO offset
    bus_write(32'h0003_0004, 8'h99);
    check("halt_set", halt, 1'b1);
    bus_read(32'h0003_0004);
    check("halt_read", mem_result, 8'h01);
    bus_write(32'h0003_0002, 8'hEE);
    bus_read(32'h0003_0002);
    check("io_other_read", mem_result, 8'h00);

    // RX path
    uart_rx_data = 8'h5A; uart_rx_valid = 1'b1;
    cyc();
    uart_rx_valid = 1'b0;
    bus_read(32'h0003_0000);
    check("rx_pop_5a", mem_result, 8'h5A);
    bus_read(32'h0003_0000);
    check("rx_empty_read", mem_result, 8'h00);
    // Push and pop together while empty
    uart_rx_data = 8'h66; uart_rx_valid = 1'b1;
    bus_read(32'h0003_0000);
    uart_rx_valid = 1'b0;
    check("rx_pushpop_empty", mem_result, 8'h00);
    bus_read(32'h0003_0000);
    check("rx_pop_66", mem_result, 8'h66);

    // rdy=0 freezes RAM and outputs
    bus_write(32'h20, 8'h11);
    bus_read(32'h10);
    rdy = 1'b0;
    bus_write(32'h20, 8'hFF);
    bus_read(32'h20);
    check("rdy0_hold", mem_result, 8'hA5);
    rdy = 1'b1;
    bus_read(32'h20);
    check("rdy0_no_write", mem_result, 8'h11);

    // TX back-pressure: 0x41.. pushed with the sink stalled
    for (int i = 0; i < 9; i++) begin
      bus_write(32'h0003_0000, 8'h41 + 8'(i));
      if (i == 5) check("cr_after6", cannot_read, 1'b0);
      if (i == 6) check("cr_after7", cannot_read, 1'b1);
      if (i == 7) check("ovf_after8", tx_overflow, 1'b0);
      if (i == 8) check("ovf_after9", tx_overflow, 1'b1);
    end
    check("tx_valid_full", uart_tx_valid, 1'b1);

    // Drain: head byte in order; cannot_read follows occupancy
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("tx_head%0d", i), uart_tx_data, 8'h41 + 8'(i));
      cyc();
      if (i == 0) check("cr_cnt7", cannot_read, 1'b1);
      if (i == 1) check("cr_cnt6", cannot_read, 1'b0);
    end
    check("tx_head3", uart_tx_data, 8'h44);

    // Asynchronous reset mid-drain
    #3;
    rst = 1'b0;
    #1;
    check("arst_tx_valid", uart_tx_valid, 1'b0);
    check("arst_cannot_read", cannot_read, 1'b0);
    check("arst_halt", halt, 1'b0);
    check("arst_tx_overflow", tx_overflow, 1'b0);
    uart_tx_ready = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    bus_read(32'h10);
    check("ram_kept_10", mem_result, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
